// File: rtl/vga_pkg.sv
// Shared definitions for the VGA debug-display blocks: fetcher state
// encoding, glyph codes understood by the character writer, and default
// register-walk geometry.
package vga_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_PRESENT = 2'd3
  } fetch_state_t;

  // Glyph codes 0..15 draw the hex digits 0-9 and A-F; the rest are labels
  localparam logic [7:0] GLYPH_DIGIT_0 = 8'd0;
  localparam logic [7:0] GLYPH_R       = 8'd16;
  localparam logic [7:0] GLYPH_COLON   = 8'd17;
  localparam logic [7:0] GLYPH_SPACE   = 8'd18;

  localparam int DEFAULT_NUM_REGS  = 8;
  localparam int DEFAULT_ADDR_W    = 9;
  localparam int MAX_READ_LATENCY  = 4;

  // Maps one hex nibble onto the glyph that draws it
  function automatic logic [7:0] nibble_to_glyph(input logic [3:0] nibble);
    return GLYPH_DIGIT_0 + {4'h0, nibble};
  endfunction

endpackage

// File: rtl/hex_nibble_splitter.sv
// Splits a 32-bit word into eight glyph codes, most significant nibble in
// the top byte, so a display can draw the word left to right.
module hex_nibble_splitter
  import vga_pkg::*;
(
  input  logic [31:0] value,
  output logic [63:0] codes
);

  // One glyph byte per nibble, byte i carries value[4i+3:4i]
  always_comb begin
    codes = '0;
    for (int i = 0; i < 8; i++) begin
      codes[8*i +: 8] = nibble_to_glyph(value[4*i +: 4]);
    end
  end

endmodule

// File: rtl/reg_row_fetcher.sv
// Walks the register file one register at a time, waits out the read
// latency, captures the value as eight hex glyph codes and hands one row per
// register to the VGA register-display writer over a valid/ready handshake.
module reg_row_fetcher
  import vga_pkg::*;
#(
  parameter int NUM_REGS     = DEFAULT_NUM_REGS,
  parameter int ADDR_W       = DEFAULT_ADDR_W,
  parameter int BASE_ADDR    = 0,
  parameter int READ_LATENCY = 1,
  parameter int CONTINUOUS   = 1
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  output logic [ADDR_W-1:0] addr,
  input  logic [31:0]       register_value,
  output logic              row_valid,
  input  logic              row_ready,
  output logic [2:0]        row_idx,
  output logic [63:0]       char_codes,
  output logic              finished_register,
  output logic              busy
);

  // row_idx is only three bits wide and the latency counter only two
  generate
    if (NUM_REGS < 1 || NUM_REGS > 8) begin : g_bad_num_regs
      $error("reg_row_fetcher: NUM_REGS must be in 1..8");
    end
    if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
      $error("reg_row_fetcher: READ_LATENCY must be in 1..4");
    end
  endgenerate

  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [1:0]        LAT_LOAD = 2'(READ_LATENCY - 1);
  localparam logic [2:0]        LAST_ROW = 3'(NUM_REGS - 1);
  localparam bit                AUTO_RUN = (CONTINUOUS != 0);

  fetch_state_t state;
  fetch_state_t state_next;

  logic [1:0]  lat_cnt;
  logic [63:0] split_codes;
  logic        handshake;
  logic        last_row;
  logic        capture;

  hex_nibble_splitter u_splitter (
    .value (register_value),
    .codes (split_codes)
  );

  assign handshake = (state == ST_PRESENT) && row_ready;
  assign last_row  = (row_idx == LAST_ROW);
  assign capture   = (state == ST_WAIT) && (lat_cnt == 2'd0);

  // State register
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: issue, wait out the latency, present until accepted
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (AUTO_RUN || start) begin
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (capture) begin
          state_next = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (handshake) begin
          if (last_row && !AUTO_RUN) begin
            state_next = ST_IDLE;
          end else begin
            state_next = ST_ISSUE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from the registered state so row_valid cannot glitch
  always_comb begin
    row_valid = (state == ST_PRESENT);
    busy      = (state != ST_IDLE);
    if (state == ST_IDLE) begin
      addr = BASE;
    end else begin
      addr = BASE + ADDR_W'(row_idx);
    end
  end

  // Row index, latency counter, captured glyphs and the end-of-sweep pulse
  always_ff @(posedge clock) begin
    if (!resetn) begin
      row_idx           <= 3'd0;
      lat_cnt           <= 2'd0;
      char_codes        <= 64'd0;
      finished_register <= 1'b0;
    end else begin
      finished_register <= handshake && last_row;

      if (state == ST_ISSUE) begin
        lat_cnt <= LAT_LOAD;
      end else if ((state == ST_WAIT) && (lat_cnt != 2'd0)) begin
        lat_cnt <= lat_cnt - 2'd1;
      end

      if (capture) begin
        char_codes <= split_codes;
      end

      if (handshake) begin
        if (last_row) begin
          row_idx <= 3'd0;
        end else begin
          row_idx <= row_idx + 3'd1;
        end
      end
    end
  end

endmodule
